mesh_resp_collector: RTL

Consumer for the systolic mesh response stream. It takes the valid-only (no backpressure) row outputs of the mesh-with-delays block and trims padding rows and columns. It converts each surviving row into an addressed accumulator/scratchpad write on a ready/valid port, and pulses a ROB completion when the last row of a tagged matmul has drained. It sits between the mesh and the accumulator write arbiter in the execute path.

---
 rtl/mesh_resp_collector.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mesh_resp_collector.sv
// Collects mesh response rows, trims padding rows/columns, and queues addressed
// writes plus ROB completions behind a small FIFO toward the accumulator arbiter.
module mesh_resp_collector #(
  parameter int DIM    = 16,
  parameter int ACC_W  = 20,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     resp_valid,
  input  logic                     resp_rob_id_valid,
  input  logic [5:0]               resp_rob_id,
  input  logic                     resp_is_acc_addr,
  input  logic                     resp_accumulate,
  input  logic                     resp_is_garbage,
  input  logic [ADDR_W-1:0]        resp_addr,
  input  logic [4:0]               resp_rows,
  input  logic [4:0]               resp_cols,
  input  logic                     resp_last,
  input  logic [DIM*ACC_W-1:0]     resp_data,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic                     wr_is_acc,
  output logic                     wr_accumulate,
  output logic [DIM-1:0]           wr_mask,
  output logic [DIM*ACC_W-1:0]     wr_data,
  output logic                     cmpl_valid,
  output logic [5:0]               cmpl_rob_id,
  output logic [$clog2(DEPTH):0]   free_cnt,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                 is_write;
    logic [ADDR_W-1:0]    addr;
    logic                 is_acc;
    logic                 accumulate;
    logic [DIM-1:0]       mask;
    logic [DIM*ACC_W-1:0] data;
    logic                 is_cmpl;
    logic [5:0]           rob_id;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  entry_t            new_entry;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [4:0]        row_idx;
  logic [DIM-1:0]    row_mask;
  logic              keep, is_cmpl_row, empty, full, push_req, push, pop;

  always_comb begin
    row_mask = '0;
    for (int c = 0; c < DIM; c++) row_mask[c] = (c < int'(resp_cols));
  end

  assign keep        = !resp_is_garbage && (row_idx < resp_rows);
  assign is_cmpl_row = resp_last && resp_rob_id_valid;

  always_comb begin
    new_entry            = '0;
    new_entry.is_write   = keep;
    new_entry.addr       = resp_addr + ADDR_W'(row_idx);
    new_entry.is_acc     = resp_is_acc_addr;
    new_entry.accumulate = resp_accumulate;
    new_entry.mask       = row_mask;
    new_entry.data       = resp_data;
    new_entry.is_cmpl    = is_cmpl_row;
    new_entry.rob_id     = resp_rob_id;
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  // Non-write entries (completion markers) retire without a handshake.
  assign pop      = !empty && (!head.is_write || wr_ready);
  assign push_req = resp_valid && (keep || is_cmpl_row);
  assign push     = push_req && (!full || pop);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push && pop) count_nxt = count - CNT_W'(1);
  end

  always_comb begin
    wr_valid      = !empty && head.is_write;
    wr_addr       = '0;
    wr_is_acc     = 1'b0;
    wr_accumulate = 1'b0;
    wr_mask       = '0;
    wr_data       = '0;
    if (!empty) begin
      wr_addr       = head.addr;
      wr_is_acc     = head.is_acc;
      wr_accumulate = head.accumulate;
      wr_mask       = head.mask;
      wr_data       = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      row_idx     <= '0;
      free_cnt    <= CNT_W'(DEPTH);
      cmpl_valid  <= 1'b0;
      cmpl_rob_id <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_nxt;
      free_cnt <= CNT_W'(DEPTH) - count_nxt;
      if (resp_valid) row_idx <= resp_last ? 5'd0 : row_idx + 5'd1;
      if (push_req && !push) overflow <= 1'b1;
      cmpl_valid <= pop && head.is_cmpl;
      if (pop && head.is_cmpl) cmpl_rob_id <= head.rob_id;
    end
  end

endmodule
